// File: rtl/dcache_wb_controller.sv
// Write-back data-cache controller: sequences dirty-line eviction and refill between L1 and L2.
// Optional whole-cache write-back walk is compiled in when DCACHE_FLUSH_ALL_EN is defined.

package dcache_wb_pkg;
  typedef enum logic [1:0] {
    MO_LOAD    = 2'd0,
    MO_STORE   = 2'd1,
    MO_UNKNOWN = 2'd3
  } memory_operation_e;
endpackage

module dcache_wb_controller
  import dcache_wb_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 64,
  localparam int WI            = $clog2(WORDS_PER_LINE),
  localparam int SI            = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hit,
  input  logic              dirty_miss,
  input  logic              clean_miss,
  input  logic              l2_fetched_word_valid,
  input  logic              l2_store_ack,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [WI-1:0]     word_index,
  output logic              flush_mode,
  output logic              load_mode,
  output logic              write_word_en,
  output logic              clear_selected_dirty_bit,
  output logic              clear_selected_valid_bit,
  output logic              finish_new_line_install,
  output logic              set_new_l2_block_address,
  input  logic              flush_all_req,
  input  logic              selected_dirty,
  output logic              set_index_override,
  output logic [SI-1:0]     set_index,
  output logic              flush_all_done,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FLUSH      = 3'd1;
  localparam logic [2:0] ST_LOAD       = 3'd2;
`ifdef DCACHE_FLUSH_ALL_EN
  localparam logic [2:0] ST_WALK_CHECK = 3'd3;
  localparam logic [2:0] ST_WALK_FLUSH = 3'd4;
`endif

  localparam logic [WI-1:0] LAST_WORD = WI'(WORDS_PER_LINE - 1);

  logic [2:0]    state, state_next;
  logic [WI-1:0] word_cnt, word_next;

  // Handshake: while l2_req_valid is high the request (type, word_index) is held stable;
  // a word moves only in a cycle where l2_store_ack (STORE) or l2_fetched_word_valid (LOAD) is high.

`ifdef DCACHE_FLUSH_ALL_EN
  localparam logic [SI-1:0] LAST_SET = SI'(NUM_SETS - 1);
  logic [SI-1:0] set_cnt, set_next;
  assign set_index = set_cnt;
`else
  logic unused_flush_inputs;
  assign unused_flush_inputs = flush_all_req ^ selected_dirty;
  assign set_index = '0;
`endif

  assign word_index = word_cnt;
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  always_comb begin
    state_next               = state;
    word_next                = word_cnt;
`ifdef DCACHE_FLUSH_ALL_EN
    set_next                 = set_cnt;
`endif
    l2_req_valid             = 1'b0;
    l2_req_type              = MO_LOAD;
    flush_mode               = 1'b0;
    load_mode                = 1'b0;
    write_word_en            = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    set_new_l2_block_address = 1'b0;
    set_index_override       = 1'b0;
    flush_all_done           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          state_next = ST_IDLE;
        end else if (dirty_miss) begin
          set_new_l2_block_address = 1'b1;
          word_next                = '0;
          state_next               = ST_FLUSH;
        end else if (clean_miss) begin
          set_new_l2_block_address = 1'b1;
          word_next                = '0;
          state_next               = ST_LOAD;
`ifdef DCACHE_FLUSH_ALL_EN
        end else if (flush_all_req) begin
          set_next   = '0;
          state_next = ST_WALK_CHECK;
`endif
        end
      end
      ST_FLUSH: begin
        l2_req_valid = 1'b1;
        l2_req_type  = MO_STORE;
        flush_mode   = 1'b1;
        if (l2_store_ack) begin
          word_next = word_cnt + 1'b1;
          if (word_cnt == LAST_WORD) begin
            set_new_l2_block_address = 1'b1;
            clear_selected_dirty_bit = 1'b1;
            clear_selected_valid_bit = 1'b1;
            word_next                = '0;
            state_next               = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        l2_req_valid = 1'b1;
        l2_req_type  = MO_LOAD;
        load_mode    = 1'b1;
        if (l2_fetched_word_valid) begin
          write_word_en = 1'b1;
          word_next     = word_cnt + 1'b1;
          if (word_cnt == LAST_WORD) begin
            finish_new_line_install = 1'b1;
            state_next              = ST_IDLE;
          end
        end
      end
`ifdef DCACHE_FLUSH_ALL_EN
      ST_WALK_CHECK: begin
        set_index_override = 1'b1;
        if (selected_dirty) begin
          set_new_l2_block_address = 1'b1;
          word_next                = '0;
          state_next               = ST_WALK_FLUSH;
        end else if (set_cnt == LAST_SET) begin
          flush_all_done = 1'b1;
          state_next     = ST_IDLE;
        end else begin
          set_next = set_cnt + 1'b1;
        end
      end
      ST_WALK_FLUSH: begin
        l2_req_valid       = 1'b1;
        l2_req_type        = MO_STORE;
        flush_mode         = 1'b1;
        set_index_override = 1'b1;
        if (l2_store_ack) begin
          word_next = word_cnt + 1'b1;
          // Walk write-back keeps the line valid; only the dirty bit is retired.
          if (word_cnt == LAST_WORD) begin
            clear_selected_dirty_bit = 1'b1;
            if (set_cnt == LAST_SET) begin
              flush_all_done = 1'b1;
              state_next     = ST_IDLE;
            end else begin
              set_next   = set_cnt + 1'b1;
              state_next = ST_WALK_CHECK;
            end
          end
        end
      end
`endif
      default: begin
        l2_req_valid             = 1'bx;
        l2_req_type              = MO_UNKNOWN;
        flush_mode               = 1'bx;
        load_mode                = 1'bx;
        write_word_en            = 1'bx;
        clear_selected_dirty_bit = 1'bx;
        clear_selected_valid_bit = 1'bx;
        finish_new_line_install  = 1'bx;
        set_new_l2_block_address = 1'bx;
        set_index_override       = 1'bx;
        flush_all_done           = 1'bx;
        word_next                = '0;
        state_next               = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      word_cnt <= word_next;
    end
  end

`ifdef DCACHE_FLUSH_ALL_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      set_cnt <= '0;
    end else begin
      set_cnt <= set_next;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Bench for dcache_wb_controller: directed transactions with randomized gaps and stray inputs,
// checked against a transaction-level model (word order queue, event counts).

module tb_dcache_wb_controller;
  import dcache_wb_pkg::*;

  localparam int W  = 4;
  localparam int NS = 4;
  localparam int WI = $clog2(W);
  localparam int SI = $clog2(NS);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              hit = 1'b0, dirty_miss = 1'b0, clean_miss = 1'b0;
  logic              l2_fetched_word_valid = 1'b0, l2_store_ack = 1'b0;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [WI-1:0]     word_index;
  logic              flush_mode, load_mode, write_word_en;
  logic              clear_selected_dirty_bit, clear_selected_valid_bit;
  logic              finish_new_line_install, set_new_l2_block_address;
  logic              flush_all_req = 1'b0;
  logic              selected_dirty;
  logic              set_index_override;
  logic [SI-1:0]     set_index;
  logic              flush_all_done, busy;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WI-1:0] exp_q[$];
  logic [NS-1:0] dirty_mem = '0;
  logic          sel_dirty_force = 1'b0;
  int dirty_clr_cnt = 0, valid_clr_cnt = 0, done_cnt = 0, wr_cnt = 0;

  dcache_wb_controller #(.WORDS_PER_LINE(W), .NUM_SETS(NS)) dut (
    .clk(clk), .reset_n(reset_n), .hit(hit), .dirty_miss(dirty_miss), .clean_miss(clean_miss),
    .l2_fetched_word_valid(l2_fetched_word_valid), .l2_store_ack(l2_store_ack),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type), .word_index(word_index),
    .flush_mode(flush_mode), .load_mode(load_mode), .write_word_en(write_word_en),
    .clear_selected_dirty_bit(clear_selected_dirty_bit),
    .clear_selected_valid_bit(clear_selected_valid_bit),
    .finish_new_line_install(finish_new_line_install),
    .set_new_l2_block_address(set_new_l2_block_address),
    .flush_all_req(flush_all_req), .selected_dirty(selected_dirty),
    .set_index_override(set_index_override), .set_index(set_index),
    .flush_all_done(flush_all_done), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // datapath stand-in: dirty bit of the indexed set
  always_comb selected_dirty = sel_dirty_force | dirty_mem[set_index];

  // event monitor, sampled mid low phase after stimulus settles
  always @(negedge clk) begin
    #2;
    if (clear_selected_dirty_bit === 1'b1) dirty_clr_cnt++;
    if (clear_selected_valid_bit === 1'b1) valid_clr_cnt++;
    if (flush_all_done === 1'b1) done_cnt++;
    if (write_word_en === 1'b1) wr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic zero_inputs();
    hit = 1'b0; dirty_miss = 1'b0; clean_miss = 1'b0;
    l2_fetched_word_valid = 1'b0; l2_store_ack = 1'b0;
  endtask

  task automatic rand_lookup();
    hit = 1'($urandom_range(0, 1));
    dirty_miss = 1'($urandom_range(0, 1));
    clean_miss = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_valid"}, l2_req_valid, 0);
    chk({tag, "_req_type"}, l2_req_type, MO_LOAD);
    chk({tag, "_flush_mode"}, flush_mode, 0);
    chk({tag, "_load_mode"}, load_mode, 0);
    chk({tag, "_wr_en"}, write_word_en, 0);
    chk({tag, "_clr_dirty"}, clear_selected_dirty_bit, 0);
    chk({tag, "_clr_valid"}, clear_selected_valid_bit, 0);
    chk({tag, "_finish"}, finish_new_line_install, 0);
    chk({tag, "_set_addr"}, set_new_l2_block_address, 0);
    chk({tag, "_override"}, set_index_override, 0);
    chk({tag, "_done"}, flush_all_done, 0);
  endtask

  function automatic bit pick(input int gap, input int cyc);
    if (gap < 0) return ($urandom_range(0, 1) == 1);
    return ((cyc % (gap + 1)) == gap);
  endfunction

  // One line of STORE words; gap<0 randomizes acks.
  task automatic store_phase(input bit walk, input int set_s, input int gap);
    int cyc = 0;
    bit ack, last;
    exp_q.delete();
    for (int i = 0; i < W; i++) exp_q.push_back(WI'(i));
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      rand_lookup();
      ack = pick(gap, cyc);
      l2_store_ack = ack;
      l2_fetched_word_valid = 1'($urandom_range(0, 1));
      #1;
      last = ack && (exp_q.size() == 1);
      chk("st_req_valid", l2_req_valid, 1);
      chk("st_req_type", l2_req_type, MO_STORE);
      chk("st_flush_mode", flush_mode, 1);
      chk("st_load_mode", load_mode, 0);
      chk("st_wr_en", write_word_en, 0);
      chk("st_word_index", word_index, exp_q[0]);
      chk("st_override", set_index_override, walk);
      if (walk) chk("st_set_index", set_index, set_s);
      chk("st_clr_dirty", clear_selected_dirty_bit, last);
      chk("st_clr_valid", clear_selected_valid_bit, last && !walk);
      chk("st_set_addr", set_new_l2_block_address, last && !walk);
      chk("st_done", flush_all_done, last && walk && (set_s == NS - 1));
      if (ack) void'(exp_q.pop_front());
      cyc++;
    end
    chk("st_timeout_words_left", exp_q.size(), 0);
  endtask

  task automatic load_phase(input int gap);
    int cyc = 0;
    bit beat, last;
    exp_q.delete();
    for (int i = 0; i < W; i++) exp_q.push_back(WI'(i));
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      rand_lookup();
      beat = pick(gap, cyc);
      l2_fetched_word_valid = beat;
      l2_store_ack = 1'($urandom_range(0, 1));
      #1;
      last = beat && (exp_q.size() == 1);
      chk("ld_req_valid", l2_req_valid, 1);
      chk("ld_req_type", l2_req_type, MO_LOAD);
      chk("ld_load_mode", load_mode, 1);
      chk("ld_flush_mode", flush_mode, 0);
      chk("ld_word_index", word_index, exp_q[0]);
      chk("ld_wr_en", write_word_en, beat);
      chk("ld_finish", finish_new_line_install, last);
      chk("ld_clr_dirty", clear_selected_dirty_bit, 0);
      if (beat) void'(exp_q.pop_front());
      cyc++;
    end
    chk("ld_timeout_words_left", exp_q.size(), 0);
  endtask

  task automatic miss(input bit dirty, input int gap);
    @(negedge clk);
    zero_inputs();
    dirty_miss = dirty;
    clean_miss = !dirty;
    #1;
    chk("miss_busy", busy, 0);
    chk("miss_req_valid", l2_req_valid, 0);
    chk("miss_set_addr", set_new_l2_block_address, 1);
    if (dirty) store_phase(1'b0, 0, gap);
    load_phase(gap);
    @(negedge clk);
    zero_inputs();
    #1;
    chk_idle("after_miss");
  endtask

`ifdef DCACHE_FLUSH_ALL_EN
  task automatic run_walk(input logic [NS-1:0] mask, input int gap);
    int d0 = dirty_clr_cnt, v0 = valid_clr_cnt, f0 = done_cnt, dirty_n = 0;
    dirty_mem = mask;
    for (int s = 0; s < NS; s++) if (mask[s]) dirty_n++;
    @(negedge clk);
    zero_inputs();
    flush_all_req = 1'b1;
    #1;
    chk("walk_start_busy", busy, 0);
    for (int s = 0; s < NS; s++) begin
      @(negedge clk);
      rand_lookup();
      #1;
      chk("wc_override", set_index_override, 1);
      chk("wc_set_index", set_index, s);
      chk("wc_req_valid", l2_req_valid, 0);
      chk("wc_set_addr", set_new_l2_block_address, dirty_mem[s]);
      chk("wc_done", flush_all_done, !dirty_mem[s] && (s == NS - 1));
      if (dirty_mem[s]) begin
        store_phase(1'b1, s, gap);
        dirty_mem[s] = 1'b0;
      end
    end
    @(negedge clk);
    zero_inputs();
    flush_all_req = 1'b0;
    #1;
    chk_idle("after_walk");
    chk("walk_dirty_clears", dirty_clr_cnt - d0, dirty_n);
    chk("walk_valid_clears", valid_clr_cnt - v0, 0);
    chk("walk_done_pulses", done_cnt - f0, 1);
  endtask
`endif

  initial begin
    int d0, v0, w0;

    // reset state
    zero_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_word_index", word_index, 0);
    chk("reset_set_index", set_index, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // hits in idle, including hit + miss together
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hit = 1'b1;
      dirty_miss = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      clean_miss = 1'($urandom_range(0, 1));
      #1;
      chk_idle("hit");
    end
    @(negedge clk);
    zero_inputs();
    #1;
    chk_idle("post_hit");

    // clean miss with a beat every cycle
    w0 = wr_cnt;
    miss(1'b0, 0);
    chk("clean_wr_count", wr_cnt - w0, W);

    // dirty miss with two-cycle ack gaps
    d0 = dirty_clr_cnt; v0 = valid_clr_cnt; w0 = wr_cnt;
    miss(1'b1, 2);
    chk("dirty_clr_dirty", dirty_clr_cnt - d0, 1);
    chk("dirty_clr_valid", valid_clr_cnt - v0, 1);
    chk("dirty_wr_count", wr_cnt - w0, W);

    // randomized misses
    for (int i = 0; i < 6; i++) miss(1'($urandom_range(0, 1)), -1);

    // reset during refill at word 2
    @(negedge clk);
    zero_inputs();
    clean_miss = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      zero_inputs();
      l2_fetched_word_valid = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_word_index", word_index, 2);
    chk("rst_mid_req_valid", l2_req_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset_n = 1'b1;
      l2_fetched_word_valid = 1'b1;
      l2_store_ack = 1'b1;
      #1;
      chk_idle("rst_abandon");
      chk("rst_abandon_word_index", word_index, 0);
    end
    @(negedge clk);
    zero_inputs();

`ifdef DCACHE_FLUSH_ALL_EN
    run_walk(4'b1010, 0);
    run_walk(4'($urandom_range(0, 15)), -1);
    miss(1'b1, -1);
`else
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      zero_inputs();
      flush_all_req = 1'b1;
      sel_dirty_force = 1'b1;
      #1;
      chk_idle("no_walk");
      chk("no_walk_set_index", set_index, 0);
    end
    @(negedge clk);
    flush_all_req = 1'b0;
    sel_dirty_force = 1'b0;
    miss(1'b0, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
